// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: drains a show-ahead TX FIFO onto the serial tx line.
// Latency: pop in cycle N -> start bit on tx from cycle N+1; outputs registered.
// Backpressure: pops only when FIFO non-empty and the line is idle or ending a frame.
module uart_tx_serializer #(
  parameter int width        = 8,
  parameter int clks_per_bit = 868,
  parameter int parity_en    = 0,
  parameter int parity_odd   = 0,
  parameter int stop_bits    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int BW = $clog2(clks_per_bit);
  localparam int IW = $clog2(width);
  localparam logic [BW-1:0] BAUD_LAST = BW'(clks_per_bit - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(width - 1);
  localparam logic          STOP_LAST = (stop_bits == 2);
  localparam logic          ODD_BIT   = (parity_odd != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_n;
  logic [BW-1:0]    baud, baud_n;
  logic [IW-1:0]    bit_idx, idx_n;
  logic             stop_cnt, stop_n;
  logic [width-1:0] shift, shift_n;
  logic             par, par_n;
  logic             tx_n, busy_n, done_n;
  logic             bit_end, last_stop;

  assign bit_end   = (baud == BAUD_LAST);
  assign last_stop = (state == STOP) && bit_end && (stop_cnt == STOP_LAST);
  // Pop whenever a new frame can start on the next edge; held off during reset.
  assign fifo_pop  = rst_n && !fifo_empty && ((state == IDLE) || last_stop);

  // Next-state, counters and the registered-output values for the next cycle.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    idx_n   = bit_idx;
    stop_n  = stop_cnt;
    shift_n = shift;
    par_n   = par;
    done_n  = 1'b0;
    case (state)
      IDLE: ;
      START: begin
        if (bit_end) begin
          state_n = DATA;
          baud_n  = '0;
          idx_n   = '0;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          if (bit_idx == IDX_LAST) begin
            state_n = (parity_en != 0) ? PARITY : STOP;
            stop_n  = 1'b0;
          end else begin
            idx_n = bit_idx + 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          baud_n  = '0;
          stop_n  = 1'b0;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (stop_cnt == STOP_LAST) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            stop_n = stop_cnt + 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // A pop overrides everything: capture the head word and parity from the same byte.
    if (fifo_pop) begin
      state_n = START;
      baud_n  = '0;
      idx_n   = '0;
      stop_n  = 1'b0;
      shift_n = fifo_data;
      par_n   = (^fifo_data) ^ ODD_BIT;
    end
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, counters and registered line outputs; reset abandons any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= idx_n;
      stop_cnt <= stop_n;
      shift    <= shift_n;
      par      <= par_n;
      tx       <= tx_n;
      busy     <= busy_n;
      tx_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 8N2) at 4 clocks/bit,
// each fed by a small show-ahead FIFO model and checked every cycle against a
// frame-level model, plus directed literal checks of the key waveforms.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int PEN [4] = '{0, 1, 1, 0};
  localparam int ODD [4] = '{0, 0, 1, 0};
  localparam int STB [4] = '{1, 1, 1, 2};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty [4];
  logic [7:0] fifo_data  [4];
  logic       fifo_pop   [4];
  logic       tx         [4];
  logic       busy       [4];
  logic       tx_done    [4];

  // FIFO model storage
  logic [7:0] fmem  [4][16];
  logic [3:0] fhead [4] = '{default: 4'd0};
  logic [3:0] ftail [4] = '{default: 4'd0};

  // Frame-level model: expected tx waveform of the frame in flight
  logic fw    [4][64];
  int   flen  [4] = '{default: 0};
  int   fpos  [4] = '{default: 0};
  logic dflag [4] = '{default: 1'b0};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.width(8), .clks_per_bit(CPB), .parity_en(PEN[0]), .parity_odd(ODD[0]), .stop_bits(STB[0])) u0 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
    .fifo_pop(fifo_pop[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]));
  uart_tx_serializer #(.width(8), .clks_per_bit(CPB), .parity_en(PEN[1]), .parity_odd(ODD[1]), .stop_bits(STB[1])) u1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
    .fifo_pop(fifo_pop[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]));
  uart_tx_serializer #(.width(8), .clks_per_bit(CPB), .parity_en(PEN[2]), .parity_odd(ODD[2]), .stop_bits(STB[2])) u2 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[2]), .fifo_data(fifo_data[2]),
    .fifo_pop(fifo_pop[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2]));
  uart_tx_serializer #(.width(8), .clks_per_bit(CPB), .parity_en(PEN[3]), .parity_odd(ODD[3]), .stop_bits(STB[3])) u3 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[3]), .fifo_data(fifo_data[3]),
    .fifo_pop(fifo_pop[3]), .tx(tx[3]), .busy(busy[3]), .tx_done(tx_done[3]));

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    assign fifo_empty[g] = (fhead[g] == ftail[g]);
    assign fifo_data[g]  = fmem[g][fhead[g]];
  end

  // The FIFO advances on the same edge as a pop.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (fifo_pop[i]) fhead[i] <= fhead[i] + 4'd1;
  end

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    fmem[i][ftail[i]] = b;
    ftail[i] = ftail[i] + 4'd1;
  endtask

  task automatic wait_pop(input int i, output int waited);
    waited = -1;
    for (int k = 0; k < 300 && waited < 0; k++) begin
      @(negedge clk);
      if (fifo_pop[i]) waited = k;
    end
    if (waited < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pop_timeout[%0d]: got no pop within 300 cycles, expected one", i);
    end
  endtask

  // Per-cycle compare against the frame model, then advance the model.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int rem, nb, bv;
      logic etx, ebusy, edone, epop;
      logic [7:0] hd;
      if (!rst_n) begin
        flen[i]  = 0;
        fpos[i]  = 0;
        dflag[i] = 1'b0;
      end
      rem   = flen[i] - fpos[i];
      etx   = (rem > 0) ? fw[i][fpos[i]] : 1'b1;
      ebusy = (rem > 0);
      edone = dflag[i];
      epop  = rst_n && !fifo_empty[i] && (rem <= 1);
      check("tx", i, int'(tx[i]), int'(etx));
      check("busy", i, int'(busy[i]), int'(ebusy));
      check("tx_done", i, int'(tx_done[i]), int'(edone));
      check("fifo_pop", i, int'(fifo_pop[i]), int'(epop));
      dflag[i] = 1'b0;
      if (rem > 0) begin
        fpos[i]++;
        if (fpos[i] == flen[i]) dflag[i] = 1'b1;
      end
      if (epop) begin
        hd = fmem[i][fhead[i]];
        nb = 9 + PEN[i] + STB[i];
        for (int k = 0; k < nb; k++) begin
          if (k == 0)                        bv = 0;
          else if (k <= 8)                   bv = int'(hd[k-1]);
          else if (PEN[i] != 0 && k == 9)    bv = int'(^hd) ^ ODD[i];
          else                               bv = 1;
          for (int c = 0; c < CPB; c++) fw[i][k*CPB + c] = bv[0];
        end
        flen[i] = nb * CPB;
        fpos[i] = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int w, npop, ndone;
    logic [9:0] a5_pat;
    a5_pat = 10'b1101001010;  // stop, 0xA5, start (start bit is bit 0)

    // Reset with a non-empty FIFO: outputs idle, no pop.
    push(0, 8'hA5); push(1, 8'h07); push(2, 8'h07); push(3, 8'h3C); push(3, 8'h55);
    repeat (2) @(negedge clk);
    check("rst_tx", 0, int'(tx[0]), 1);
    check("rst_busy", 0, int'(busy[0]), 0);
    check("rst_done", 0, int'(tx_done[0]), 0);
    check("rst_pop", 0, int'(fifo_pop[0]), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    wait_pop(0, w);
    check("pop_after_release", 0, w, 0);
    for (int i = 1; i < 4; i++) check("pop_cycle0", i, int'(fifo_pop[i]), 1);

    // Single frames on all four instances, pop at cycle 0.
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c <= 40) check("a5_tx", 0, int'(tx[0]), int'(a5_pat[(c-1)/4]));
      if (c == 41) begin
        check("a5_done", 0, int'(tx_done[0]), 1);
        check("a5_busy_low", 0, int'(busy[0]), 0);
      end
      if (c >= 37 && c <= 40) begin
        check("parity_even", 1, int'(tx[1]), 1);
        check("parity_odd", 2, int'(tx[2]), 0);
      end
      if (c == 45) begin
        check("par_done", 1, int'(tx_done[1]), 1);
        check("par_done", 2, int'(tx_done[2]), 1);
      end
      if (c >= 37 && c <= 44) check("two_stop_high", 3, int'(tx[3]), 1);
      if (c == 44) check("two_stop_pop", 3, int'(fifo_pop[3]), 1);
      if (c == 45) begin
        check("two_stop_next_start", 3, int'(tx[3]), 0);
        check("two_stop_done", 3, int'(tx_done[3]), 1);
      end
    end
    repeat (50) @(negedge clk);

    // Back-to-back 0x00, 0xFF.
    @(posedge clk); #2 push(0, 8'h00); push(0, 8'hFF);
    wait_pop(0, w);
    npop = 1;
    ndone = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (fifo_pop[0]) npop++;
      if (tx_done[0]) ndone++;
      if (c == 40) check("b2b_second_pop", 0, int'(fifo_pop[0]), 1);
      if (c == 41) begin
        check("b2b_start", 0, int'(tx[0]), 0);
        check("b2b_busy", 0, int'(busy[0]), 1);
      end
    end
    check("b2b_pop_count", 0, npop, 2);
    check("b2b_done_count", 0, ndone, 2);

    // Mid-frame reset in cycle 15 of a 0x5A frame (tx low there: data bit 2 = 0).
    @(posedge clk); #2 push(0, 8'h5A); push(0, 8'h33);
    wait_pop(0, w);
    repeat (14) @(negedge clk);
    check("pre_reset_tx", 0, int'(tx[0]), 0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", 0, int'(tx[0]), 1);
    check("async_rst_busy", 0, int'(busy[0]), 0);
    npop = 0;
    repeat (3) begin
      @(negedge clk);
      if (fifo_pop[0]) npop++;
    end
    check("pop_in_reset", 0, npop, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    wait_pop(0, w);
    check("pop_after_mid_reset", 0, w, 0);
    for (int c = 1; c <= 41; c++) begin
      @(negedge clk);
      if (c == 1) check("new_frame_start", 0, int'(tx[0]), 0);
      if (c == 5) check("new_frame_bit0", 0, int'(tx[0]), 1);
      if (c == 41) check("new_frame_done", 0, int'(tx_done[0]), 1);
    end
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
